// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: writeback pipe register, access widths,
// FSM states and byte-lane helpers.
package mem_access_stage_pkg;

    typedef logic [31:0] BasicData;
    typedef logic [6:0]  RdCtrl;

    localparam int RD_WEN_BIT = 6;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } MemAccessWidth;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } MemStageState;

    typedef struct packed {
        logic     valid;
        BasicData pc;
        BasicData data;
        RdCtrl    rdCtrl;
        logic     busErr;
        logic     misalign;
    } WritebackStagePipeReg;

    // Reserved width code 3 behaves as a word access.
    function automatic logic [3:0] laneEnable(
        input logic [1:0] width,
        input logic [1:0] a
    );
        logic [3:0] be;
        case (width)
            MEM_BYTE: be = 4'b0001 << a;
            MEM_HALF: be = 4'b0011 << {a[1], 1'b0};
            default:  be = 4'hF;
        endcase
        return be;
    endfunction

    function automatic BasicData laneData(
        input logic [1:0] width,
        input BasicData   d
    );
        BasicData w;
        case (width)
            MEM_BYTE: w = {4{d[7:0]}};
            MEM_HALF: w = {2{d[15:0]}};
            default:  w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_aligner.sv
// Load data alignment: shifts the raw read word down to the addressed
// lane, then sign- or zero-extends to 32 bits.
module load_aligner
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [1:0]  width,
    input  logic        uns,
    output logic [31:0] data
);

    logic [4:0] shamt;
    BasicData   shifted;

    always_comb begin
        shamt = 5'd0;
        case (width)
            MEM_BYTE: shamt = {a, 3'b000};
            MEM_HALF: shamt = {a[1], 4'b0000};
            default:  shamt = 5'd0;
        endcase
        shifted = rdata >> shamt;
        data = shifted;
        case (width)
            MEM_BYTE: data = uns ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
            MEM_HALF: data = uns ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory port, load alignment, front-pipe stall,
// writeback pipe register. Optional macro MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_wdata,
    input  logic [1:0]  in_width,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic        in_is_load_uns,
    input  logic [6:0]  in_rd_ctrl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] bypass_mem_data,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_data,
    output logic [6:0]  wb_rd_ctrl,
    output logic        wb_bus_err,
    output logic        wb_misalign
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    MemStageState         state;
    MemStageState         nextState;
    logic [7:0]           waitCnt;
    WritebackStagePipeReg wbReg;
    WritebackStagePipeReg wbNext;

    logic     memOp;
    logic     isWrite;
    logic     isRead;
    logic     misaligned;
    logic     req;
    logic     timeout;
    logic     done;
    BasicData loadData;

    assign memOp   = in_valid & (in_is_load | in_is_store);
    // A load+store encoding is handled as a store.
    assign isWrite = in_is_store;
    assign isRead  = in_is_load & ~in_is_store;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (in_width)
            MEM_BYTE: misaligned = 1'b0;
            MEM_HALF: misaligned = in_alu_result[0];
            default:  misaligned = |in_alu_result[1:0];
        endcase
        misaligned = misaligned & memOp;
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        nextState = state;
        req       = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            MEM_IDLE: begin
                req = memOp & ~misaligned;
                if (req & ~dmem_ack) nextState = MEM_WAIT;
            end
            MEM_WAIT: begin
                req     = 1'b1;
                timeout = ~dmem_ack & (waitCnt == TIMEOUT_LAST);
                if (dmem_ack | timeout) nextState = MEM_IDLE;
            end
            default: nextState = MEM_IDLE;
        endcase
        // Reset drops the request at once, even while inputs still show an op.
        if (rst) begin
            req     = 1'b0;
            timeout = 1'b0;
        end
    end

    assign done  = req & dmem_ack;
    assign stall = req & ~dmem_ack & ~timeout;

    assign dmem_req   = req;
    assign dmem_we    = req & isWrite;
    assign dmem_addr  = {in_alu_result[31:2], 2'b00};
    assign dmem_be    = req ? laneEnable(in_width, in_alu_result[1:0]) : 4'h0;
    assign dmem_wdata = laneData(in_width, in_wdata);

    load_aligner uAligner (
        .rdata (dmem_rdata),
        .a     (in_alu_result[1:0]),
        .width (in_width),
        .uns   (in_is_load_uns),
        .data  (loadData)
    );

    always_comb begin
        wbNext.valid    = in_valid;
        wbNext.pc       = in_pc;
        wbNext.data     = (isRead & done) ? loadData : in_alu_result;
        wbNext.rdCtrl   = in_rd_ctrl;
        wbNext.busErr   = timeout;
        wbNext.misalign = misaligned;
        if (timeout | misaligned) wbNext.rdCtrl[RD_WEN_BIT] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MEM_IDLE;
            waitCnt <= 8'd0;
        end else begin
            state <= nextState;
            if (state == MEM_WAIT && nextState == MEM_WAIT)
                waitCnt <= waitCnt + 8'd1;
            else
                waitCnt <= 8'd0;
        end
    end

    // Stalled edges insert a bubble but keep the last result for bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbReg <= '0;
        end else if (stall) begin
            wbReg.valid <= 1'b0;
        end else begin
            wbReg <= wbNext;
        end
    end

    assign wb_valid        = wbReg.valid;
    assign wb_pc           = wbReg.pc;
    assign wb_data         = wbReg.data;
    assign wb_rd_ctrl      = wbReg.rdCtrl;
    assign wb_bus_err      = wbReg.busErr;
    assign wb_misalign     = wbReg.misalign;
    assign bypass_mem_data = wbReg.data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus
// multi-cycle wait, timeout, misalignment and reset sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_wdata = '0;
    logic [1:0]  in_width = '0;
    logic        in_is_load = 1'b0;
    logic        in_is_store = 1'b0;
    logic        in_is_load_uns = 1'b0;
    logic [6:0]  in_rd_ctrl = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall;
    logic [31:0] bypass_mem_data;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_data;
    logic [6:0]  wb_rd_ctrl;
    logic        wb_bus_err;
    logic        wb_misalign;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc),
        .in_alu_result(in_alu_result), .in_wdata(in_wdata),
        .in_width(in_width), .in_is_load(in_is_load),
        .in_is_store(in_is_store), .in_is_load_uns(in_is_load_uns),
        .in_rd_ctrl(in_rd_ctrl),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall),
        .bypass_mem_data(bypass_mem_data),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_data(wb_data),
        .wb_rd_ctrl(wb_rd_ctrl), .wb_bus_err(wb_bus_err),
        .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [6:0]  rd;
        logic        busErr;
        logic        misalign;
    } WbExp;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [1:0]  width;
        logic        ld;
        logic        st;
        logic        uns;
        logic [6:0]  rd;
        logic [31:0] rdata;
        logic        eReq;
        logic        eWe;
        logic [3:0]  eBe;
        logic [31:0] eWd;
        logic [31:0] eData;
    } Vec;

    WbExp sb[$];
    Vec   vecs[13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] data,
                        input logic [6:0] rd, input logic be,
                        input logic mis);
        WbExp e;
        e.pc = pc;
        e.data = data;
        e.rd = rd;
        e.busErr = be;
        e.misalign = mis;
        sb.push_back(e);
    endtask

    task automatic edgeCheck(input string tag, input logic expValid);
        WbExp e;
        @(posedge clk);
        #1;
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(expValid));
        if (wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: unexpected writeback pc 0x%08h", tag, wb_pc);
            end else begin
                e = sb.pop_front();
                chk({tag, " wb_pc"}, wb_pc, e.pc);
                chk({tag, " wb_data"}, wb_data, e.data);
                chk({tag, " bypass"}, bypass_mem_data, e.data);
                chk({tag, " wb_rd_ctrl"}, 32'(wb_rd_ctrl), 32'(e.rd));
                chk({tag, " wb_bus_err"}, 32'(wb_bus_err), 32'(e.busErr));
                chk({tag, " wb_misalign"}, 32'(wb_misalign), 32'(e.misalign));
            end
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] alu,
                         input logic [1:0] w, input logic ld,
                         input logic st, input logic uns);
        in_valid = 1'b1;
        in_pc = pc;
        in_alu_result = alu;
        in_width = w;
        in_is_load = ld;
        in_is_store = st;
        in_is_load_uns = uns;
        in_rd_ctrl = 7'h4A;
    endtask

    task automatic waitLoad(input logic uns, input logic [31:0] expData);
        int  stalls = 0;
        bit  fin = 1'b0;
        string tag;
        tag = uns ? "lbu_wait" : "lb_wait";
        drive(32'h78, 32'h102, 2'd0, 1'b1, 1'b0, uns);
        dmem_rdata = 32'h0080_0000;
        push(32'h78, expData, 7'h4A, 1'b0, 1'b0);
        for (int c = 0; c < 10 && !fin; c++) begin
            dmem_ack = (c == 3);
            @(negedge clk);
            chk({tag, " req"}, 32'(dmem_req), 32'd1);
            if (stall) stalls++;
            fin = !stall;
            edgeCheck(tag, fin);
        end
        in_valid = 1'b0;
        dmem_ack = 1'b0;
        chk({tag, " stall cycles"}, 32'(stalls), 32'd3);
    endtask

    initial begin
        Vec v;
        string tag;
        int stalls;
        int reqCycles;
        bit fin;

        vecs = '{
            '{1'b1, 32'h40, 32'h1234, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 7'h4A, 32'h0,
              1'b0, 1'b0, 4'h0, 32'h0, 32'h1234},
            '{1'b1, 32'h44, 32'h103, 32'hAB, 2'd0, 1'b0, 1'b1, 1'b0, 7'h00, 32'h0,
              1'b1, 1'b1, 4'h8, 32'hABABABAB, 32'h103},
            '{1'b1, 32'h48, 32'h102, 32'h1234CDEF, 2'd1, 1'b0, 1'b1, 1'b0, 7'h00, 32'h0,
              1'b1, 1'b1, 4'hC, 32'hCDEFCDEF, 32'h102},
            '{1'b1, 32'h4C, 32'h204, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 1'b0, 7'h00, 32'h0,
              1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h204},
            '{1'b1, 32'h50, 32'h101, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 7'h4A, 32'h00008000,
              1'b1, 1'b0, 4'h2, 32'h0, 32'hFFFFFF80},
            '{1'b1, 32'h54, 32'h101, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 7'h4A, 32'h00008000,
              1'b1, 1'b0, 4'h2, 32'h0, 32'h00000080},
            '{1'b1, 32'h58, 32'h103, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 7'h4A, 32'h7F000000,
              1'b1, 1'b0, 4'h8, 32'h0, 32'h0000007F},
            '{1'b1, 32'h5C, 32'h102, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0, 7'h4A, 32'h80010000,
              1'b1, 1'b0, 4'hC, 32'h0, 32'hFFFF8001},
            '{1'b1, 32'h60, 32'h100, 32'h0, 2'd1, 1'b1, 1'b0, 1'b1, 7'h4A, 32'h1234F00D,
              1'b1, 1'b0, 4'h3, 32'h0, 32'h0000F00D},
            '{1'b1, 32'h64, 32'h108, 32'h0, 2'd2, 1'b1, 1'b0, 1'b0, 7'h4A, 32'hCAFEBABE,
              1'b1, 1'b0, 4'hF, 32'h0, 32'hCAFEBABE},
            '{1'b1, 32'h68, 32'h10C, 32'h0, 2'd3, 1'b1, 1'b0, 1'b0, 7'h4A, 32'h01234567,
              1'b1, 1'b0, 4'hF, 32'h0, 32'h01234567},
            '{1'b1, 32'h6C, 32'h110, 32'h55AA55AA, 2'd2, 1'b1, 1'b1, 1'b0, 7'h4A, 32'hFFFFFFFF,
              1'b1, 1'b1, 4'hF, 32'h55AA55AA, 32'h110},
            '{1'b0, 32'h70, 32'h200, 32'h0, 2'd2, 1'b1, 1'b0, 1'b0, 7'h4A, 32'h0,
              1'b0, 1'b0, 4'h0, 32'h0, 32'h0}
        };

        // Reset state, with a live load on the inputs to show req is gated.
        in_valid = 1'b1;
        in_is_load = 1'b1;
        #12;
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_we", 32'(dmem_we), 32'd0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst wb_pc", wb_pc, 32'd0);
        chk("rst wb_rd_ctrl", 32'(wb_rd_ctrl), 32'd0);
        chk("rst wb_bus_err", 32'(wb_bus_err), 32'd0);
        chk("rst wb_misalign", 32'(wb_misalign), 32'd0);
        in_valid = 1'b0;
        in_is_load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            in_valid = v.valid;
            in_pc = v.pc;
            in_alu_result = v.alu;
            in_wdata = v.wd;
            in_width = v.width;
            in_is_load = v.ld;
            in_is_store = v.st;
            in_is_load_uns = v.uns;
            in_rd_ctrl = v.rd;
            dmem_rdata = v.rdata;
            dmem_ack = v.eReq;
            if (v.valid) push(v.pc, v.eData, v.rd, 1'b0, 1'b0);
            @(negedge clk);
            chk({tag, " dmem_req"}, 32'(dmem_req), 32'(v.eReq));
            chk({tag, " stall"}, 32'(stall), 32'd0);
            chk({tag, " dmem_be"}, 32'(dmem_be), 32'(v.eBe));
            if (v.eReq) begin
                chk({tag, " dmem_we"}, 32'(dmem_we), 32'(v.eWe));
                chk({tag, " dmem_addr"}, dmem_addr, {v.alu[31:2], 2'b00});
            end
            if (v.eWe) chk({tag, " dmem_wdata"}, dmem_wdata, v.eWd);
            edgeCheck(tag, v.valid);
        end
        in_valid = 1'b0;
        dmem_ack = 1'b0;

        waitLoad(1'b0, 32'hFFFFFF80);
        waitLoad(1'b1, 32'h00000080);

        // Never-acked load: aborted with bus_err and rd_wen cleared.
        drive(32'h80, 32'h100, 2'd1, 1'b1, 1'b0, 1'b0);
        push(32'h80, 32'h100, 7'h0A, 1'b1, 1'b0);
        stalls = 0;
        reqCycles = 0;
        fin = 1'b0;
        for (int c = 0; c < 12 && !fin; c++) begin
            @(negedge clk);
            if (dmem_req) reqCycles++;
            if (stall) stalls++;
            fin = !stall;
            edgeCheck("timeout", fin);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("timeout req dropped", 32'(dmem_req), 32'd0);
        chk("timeout stall cycles", 32'(stalls), 32'd4);
        chk("timeout req cycles", 32'(reqCycles), 32'd5);
        @(posedge clk);
        #1;

        // Misaligned word and half accesses.
        for (int k = 0; k < 2; k++) begin
            tag = (k == 0) ? "mis_lw" : "mis_lh";
            if (k == 0) drive(32'h90, 32'h102, 2'd2, 1'b1, 1'b0, 1'b0);
            else        drive(32'h94, 32'h101, 2'd1, 1'b1, 1'b0, 1'b1);
            dmem_rdata = 32'h89AB8001;
`ifdef MISALIGN_TRAP_EN
            dmem_ack = 1'b0;
            push(in_pc, in_alu_result, 7'h0A, 1'b0, 1'b1);
            @(negedge clk);
            chk({tag, " dmem_req"}, 32'(dmem_req), 32'd0);
            chk({tag, " stall"}, 32'(stall), 32'd0);
`else
            dmem_ack = 1'b1;
            push(in_pc, (k == 0) ? 32'h89AB8001 : 32'h00008001, 7'h4A, 1'b0, 1'b0);
            @(negedge clk);
            chk({tag, " dmem_req"}, 32'(dmem_req), 32'd1);
            chk({tag, " dmem_addr"}, dmem_addr, 32'h100);
            chk({tag, " dmem_be"}, 32'(dmem_be), (k == 0) ? 32'hF : 32'h3);
`endif
            edgeCheck(tag, 1'b1);
        end
        in_valid = 1'b0;
        dmem_ack = 1'b0;

        // Reset in the middle of a wait; a late ack must be ignored.
        drive(32'hA0, 32'h120, 2'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstwait req", 32'(dmem_req), 32'd1);
        chk("rstwait stall", 32'(stall), 32'd1);
        edgeCheck("rstwait", 1'b0);
        @(negedge clk);
        chk("rstwait wait stall", 32'(stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstwait req drop", 32'(dmem_req), 32'd0);
        chk("rstwait stall drop", 32'(stall), 32'd0);
        chk("rstwait wb_valid", 32'(wb_valid), 32'd0);
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("rstwait ack ignored req", 32'(dmem_req), 32'd0);
        chk("rstwait ack ignored wb", 32'(wb_valid), 32'd0);
        in_valid = 1'b0;
        dmem_ack = 1'b0;
        #2;
        rst = 1'b0;
        edgeCheck("post_rst idle", 1'b0);
        chk("post_rst req", 32'(dmem_req), 32'd0);

        drive(32'hB0, 32'h5678, 2'd2, 1'b0, 1'b0, 1'b0);
        push(32'hB0, 32'h5678, 7'h4A, 1'b0, 1'b0);
        edgeCheck("post_rst op", 1'b1);
        in_valid = 1'b0;

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
